// File: rtl/uart_tx_ctrl_if.sv
// Request/line-mux bundle between a UART payload source and uart_tx_ctrl.
// The source (master) offers a payload. The controller (slave) returns the
// line-mux select, the current payload bit, the parity bit and busy.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  mux_sel,
        input  ser_data,
        input  par_bit,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output mux_sel,
        output ser_data,
        output par_bit,
        output busy
    );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller.
// It sequences one frame: start, DATA_WIDTH payload bits sent LSB first,
// an optional parity bit, then stop. It also drives the select for an
// external registered line mux. One serial bit goes out per clk cycle.
// A new request is accepted in IDLE, or in STOP so that frames can run
// back-to-back without a gap. Outputs are Moore-decoded from the state
// registers, so no input reaches an output combinationally.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Line-mux select codes.
    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_reg;
    logic                  par_en_reg;

    // A request is taken only when the line is idle or finishing a stop bit.
    logic accept;
    assign accept = bus.data_valid && ((state == IDLE) || (state == STOP));

    // Frame sequencer: state, bit counter and the payload latched at acceptance.
    // NOTE: every register here uses non-blocking assignment. All of them then
    // update together at the edge, and none sees another's new value early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the payload and parity registers are reset as well. Right
            // after reset, par_bit and the latched payload must read 0.
            state      <= IDLE;
            bit_cnt    <= '0;
            data_reg   <= '0;
            par_reg    <= 1'b0;
            par_en_reg <= 1'b0;
        end else begin
            if (accept) begin
                // Parity is taken from p_data itself, not from data_reg. The
                // value is then valid and constant for the whole frame.
                data_reg   <= bus.p_data;
                par_reg    <= (^bus.p_data) ^ bus.par_typ;
                par_en_reg <= bus.par_en;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (accept) begin
                        state <= START;
                    end
                end

                START: begin
                    bit_cnt <= '0;
                    state   <= DATA;
                end

                DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        state   <= par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                PARITY: begin
                    bit_cnt <= '0;
                    state   <= STOP;
                end

                STOP: begin
                    bit_cnt <= '0;
                    state   <= accept ? START : IDLE;
                end

                // Any unused encoding falls back to IDLE on the next edge.
                default: begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of the line-mux select, the payload bit and busy.
    // NOTE: every output gets a default first. No path through the case can
    // leave one unassigned, so no latch is inferred.
    always_comb begin
        bus.mux_sel  = SEL_STOP;
        bus.ser_data = 1'b0;
        bus.busy     = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
            end
            START: begin
                bus.mux_sel = SEL_START;
            end
            DATA: begin
                bus.mux_sel  = SEL_DATA;
                bus.ser_data = data_reg[bit_cnt];
            end
            PARITY: begin
                bus.mux_sel = SEL_PARITY;
            end
            STOP: begin
                bus.mux_sel = SEL_STOP;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.par_bit = par_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (DATA_WIDTH = 8).
// Inputs are driven 1 time unit after a rising edge, and outputs are read
// at the same point.
module tb_uart_tx_ctrl;

    logic clk;
    logic rst;

    int checks;
    int errors;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"},  32'(bus.mux_sel),  32'h3);
        check({tag, "_busy"}, 32'(bus.busy),     32'h0);
        check({tag, "_ser"},  32'(bus.ser_data), 32'h0);
    endtask

    // Entered one unit after the acceptance edge, with START showing.
    // Walks the frame and returns one unit after the edge that enters STOP.
    // A one-cycle request with inj_data can be injected during data bit
    // inj_at. The request line is then left at hold_dv.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pen,
                                input logic exp_par, input int exp_len, input int inj_at,
                                input logic [7:0] inj_data, input logic hold_dv);
        int busy_cycles;
        busy_cycles = 0;
        check({tag, "_start_sel"}, 32'(bus.mux_sel), 32'h0);
        busy_cycles += int'(bus.busy);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == inj_at) begin
                bus.p_data     = inj_data;
                bus.data_valid = 1'b1;
            end else if (i == inj_at + 1) begin
                bus.data_valid = hold_dv;
            end
            check($sformatf("%s_d%0d_sel", tag, i), 32'(bus.mux_sel),  32'h1);
            check($sformatf("%s_d%0d_ser", tag, i), 32'(bus.ser_data), 32'(d[i]));
            busy_cycles += int'(bus.busy);
        end
        if (pen) begin
            tick();
            check({tag, "_par_sel"}, 32'(bus.mux_sel), 32'h2);
            check({tag, "_par_bit"}, 32'(bus.par_bit), 32'(exp_par));
            busy_cycles += int'(bus.busy);
        end
        tick();
        check({tag, "_stop_sel"}, 32'(bus.mux_sel),  32'h3);
        check({tag, "_stop_ser"}, 32'(bus.ser_data), 32'h0);
        busy_cycles += int'(bus.busy);
        check({tag, "_busy_len"}, 32'(busy_cycles), 32'(exp_len));
    endtask

    // Raise a request, let the next edge accept it, then drop the request.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
        bus.p_data     = d;
        bus.par_en     = pen;
        bus.par_typ    = ptyp;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        bus.p_data     = 8'h00;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;

        // Reset values, read before any clock edge.
        #2;
        check_idle("reset");
        check("reset_par_bit", 32'(bus.par_bit), 32'h0);

        // A5 with even parity. The request is already up at reset release,
        // so the first edge after release must accept it.
        bus.p_data     = 8'hA5;
        bus.par_en     = 1'b1;
        bus.par_typ    = 1'b0;
        bus.data_valid = 1'b1;
        #10 rst = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        check("a5_start_busy", 32'(bus.busy), 32'h1);
        expect_frame("a5", 8'b1010_0101, 1'b1, 1'b0, 11, -9, 8'h00, 1'b0);
        tick();
        check_idle("a5_end");

        // 01: odd parity gives 0, even parity gives 1.
        send(8'h01, 1'b1, 1'b1);
        expect_frame("p01odd", 8'h01, 1'b1, 1'b0, 11, -9, 8'h00, 1'b0);
        tick();
        check_idle("p01odd_end");
        send(8'h01, 1'b1, 1'b0);
        expect_frame("p01even", 8'h01, 1'b1, 1'b1, 11, -9, 8'h00, 1'b0);
        tick();
        check_idle("p01even_end");

        // FF without parity: DATA goes straight to STOP, 10 busy cycles.
        send(8'hFF, 1'b0, 1'b0);
        expect_frame("ff", 8'hFF, 1'b0, 1'b0, 10, -9, 8'h00, 1'b0);
        tick();
        check_idle("ff_end");

        // Back-to-back: the request stays high throughout. p_data moves to
        // C3 mid-frame, so STOP is followed directly by a START for C3.
        bus.p_data     = 8'h3C;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        bus.data_valid = 1'b1;
        tick();
        expect_frame("b2b1", 8'b0011_1100, 1'b0, 1'b0, 10, 3, 8'hC3, 1'b1);
        tick();
        check("b2b_gap_busy", 32'(bus.busy), 32'h1);
        expect_frame("b2b2", 8'b1100_0011, 1'b0, 1'b0, 10, 0, 8'hC3, 1'b0);
        tick();
        check_idle("b2b_end");

        // A request for 55 pulsed during the DATA bits of a 0F frame is ignored.
        send(8'h0F, 1'b0, 1'b0);
        expect_frame("ign", 8'h0F, 1'b0, 1'b0, 10, 4, 8'h55, 1'b0);
        tick();
        check_idle("ign_end");
        tick();
        check_idle("ign_end2");

        // Reset asserted during data bit 4 takes effect with no clock edge.
        send(8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("rst_mid_sel_before", 32'(bus.mux_sel), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_idle("rst_mid");
        check("rst_mid_par_bit", 32'(bus.par_bit), 32'h0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("rst_after%0d", i));
        end

        // First request after the abort starts a fresh frame.
        send(8'h5A, 1'b1, 1'b1);
        expect_frame("fresh", 8'b0101_1010, 1'b1, 1'b1, 11, -9, 8'h00, 1'b0);
        tick();
        check_idle("fresh_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
